// File: rtl/cascade_pkg.sv
// cascade_pkg: types and default image/window geometry shared by the cascade
// blocks (window position source, position matching, classifier).
package cascade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } window_pos_gen_state_e;

    localparam int CASCADE_IMG_WIDTH  = 45;
    localparam int CASCADE_IMG_HEIGHT = 45;
    localparam int CASCADE_WIN_WIDTH  = 24;
    localparam int CASCADE_WIN_HEIGHT = 24;

endpackage

// File: rtl/window_pos_gen_step_counter.sv
// step_counter: stride-STEP up-counter with clear, wrap past MAX and a registered
// at_last flag that is high while the next increment would wrap.
module step_counter #(
    parameter int W    = 6,
    parameter int STEP = 1,
    parameter int MAX  = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         at_last_o
);

    localparam logic [W:0]   STEP_W = (W+1)'(STEP);
    localparam logic [W:0]   MAX_W  = (W+1)'(MAX);
    localparam logic [W-1:0] STEP_N = W'(STEP);

    logic [W-1:0] cnt_q, cnt_d;
    logic         last_q, last_d;

    // One extra bit so cnt+STEP cannot wrap before the limit compare.
    function automatic logic is_last(input logic [W-1:0] c);
        return ({1'b0, c} + STEP_W) > MAX_W;
    endfunction

    always_comb begin
        cnt_d  = clr_i ? '0 : !inc_i ? cnt_q : last_q ? '0 : cnt_q + STEP_N;
        last_d = is_last(cnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= is_last('0);
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign at_last_o = last_q;

endmodule

// File: rtl/window_pos_gen.sv
// window_pos_gen: raster-order detection-window position source with valid/ready/eot.
// Define WINDOW_POS_GEN_FRAME_CNT_EN to add a 16-bit completed-frame counter output.
module window_pos_gen
    import cascade_pkg::*;
#(
    parameter int  IMG_WIDTH  = CASCADE_IMG_WIDTH,
    parameter int  IMG_HEIGHT = CASCADE_IMG_HEIGHT,
    parameter int  WIN_WIDTH  = CASCADE_WIN_WIDTH,
    parameter int  WIN_HEIGHT = CASCADE_WIN_HEIGHT,
    parameter int  STEP       = 1,
    localparam int W_X        = $clog2(IMG_WIDTH),
    localparam int W_Y        = $clog2(IMG_HEIGHT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           window_pos_valid,
    input  logic           window_pos_ready,
    output logic           window_pos_eot,
    output logic [W_X-1:0] window_pos_x,
    output logic [W_Y-1:0] window_pos_y
`ifdef WINDOW_POS_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt
`endif
);

    localparam int X_MAX = IMG_WIDTH - WIN_WIDTH;
    localparam int Y_MAX = IMG_HEIGHT - WIN_HEIGHT;

    window_pos_gen_state_e state_q, state_d;
    logic launch, xfer, x_last, y_last;

    assign launch = state_q == IDLE && start;
    assign xfer   = state_q == SCAN && window_pos_ready;

    step_counter #(.W(W_X), .STEP(STEP), .MAX(X_MAX)) u_x (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (launch),
        .inc_i     (xfer),
        .cnt_o     (window_pos_x),
        .at_last_o (x_last)
    );

    // y advances only when x wraps back to column 0.
    step_counter #(.W(W_Y), .STEP(STEP), .MAX(Y_MAX)) u_y (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (launch),
        .inc_i     (xfer && x_last),
        .cnt_o     (window_pos_y),
        .at_last_o (y_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = (xfer && x_last && y_last) ? DONE : SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy             = state_q != IDLE;
    assign done             = state_q == DONE;
    assign window_pos_valid = state_q == SCAN;
    assign window_pos_eot   = window_pos_valid && x_last && y_last;

`ifdef WINDOW_POS_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)                       frame_cnt_q <= '0;
        else if (xfer && window_pos_eot) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_window_pos_gen.sv
// tb_window_pos_gen: three configurations (default, STEP=4, window==image) checked
// every cycle against an index-based raster model plus literal frame expectations.
module tb_window_pos_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start [3];
    logic       ready [3];
    logic       busy  [3];
    logic       done  [3];
    logic       valid [3];
    logic       eot   [3];
    logic [5:0] px    [3];
    logic [5:0] py    [3];
`ifdef WINDOW_POS_GEN_FRAME_CNT_EN
    logic [15:0] fc   [3];
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int xm [3] = '{21, 21, 0};
    int st [3] = '{1, 4, 1};
    int ph [3] = '{0, 0, 0};
    int idx [3] = '{0, 0, 0};
    int xfers [3] = '{0, 0, 0};
    int eot_cnt [3] = '{0, 0, 0};
    int lx [3] = '{-1, -1, -1};
    int ly [3] = '{-1, -1, -1};
    int frames [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        window_pos_gen #(
            .WIN_WIDTH  (g == 2 ? 45 : 24),
            .WIN_HEIGHT (g == 2 ? 45 : 24),
            .STEP       (g == 1 ? 4 : 1)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .start            (start[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .window_pos_valid (valid[g]),
            .window_pos_ready (ready[g]),
            .window_pos_eot   (eot[g]),
            .window_pos_x     (px[g]),
            .window_pos_y     (py[g])
`ifdef WINDOW_POS_GEN_FRAME_CNT_EN
            ,
            .frame_cnt        (fc[g])
`endif
        );
    end

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic int ncols(input int k);
        return xm[k] / st[k] + 1;
    endfunction

    // Model: position n of a frame is column n%ncols, row n/ncols, scaled by STEP.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                int nxp;
                nxp = ph[k];
                chk("valid", k, int'(valid[k]), int'(ph[k] == 1));
                chk("busy", k, int'(busy[k]), int'(ph[k] != 0));
                chk("done", k, int'(done[k]), int'(ph[k] == 2));
`ifdef WINDOW_POS_GEN_FRAME_CNT_EN
                chk("frame_cnt", k, int'(fc[k]), frames[k] & 16'hffff);
`endif
                if (ph[k] == 1) begin
                    chk("x", k, int'(px[k]), (idx[k] % ncols(k)) * st[k]);
                    chk("y", k, int'(py[k]), (idx[k] / ncols(k)) * st[k]);
                    chk("eot", k, int'(eot[k]), int'(idx[k] == ncols(k) * ncols(k) - 1));
                    if (ready[k] && !rst) begin
                        if (eot[k]) begin
                            eot_cnt[k]++;
                            lx[k] = int'(px[k]);
                            ly[k] = int'(py[k]);
                        end
                        xfers[k]++;
                        idx[k]++;
                        if (idx[k] == ncols(k) * ncols(k)) begin
                            nxp = 2;
                            frames[k]++;
                        end
                    end
                end else begin
                    chk("eot_idle", k, int'(eot[k]), 0);
                    if (ph[k] == 2) nxp = 0;
                    else if (start[k]) begin
                        nxp = 1;
                        idx[k] = 0;
                    end
                end
                if (rst) begin
                    nxp = 0;
                    frames[k] = 0;
                end
                ph[k] = nxp;
            end
        end
    end

    task automatic run_frame(input int k, input bit rnd, input bit poke, input int exp_cyc,
                             input int exp_n, input int exp_x, input int exp_y);
        int n;
        xfers[k]   = 0;
        eot_cnt[k] = 0;
        lx[k]      = -1;
        ly[k]      = -1;
        @(posedge clk);
        #1 start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
        n = 0;
        while (!done[k] && n < 5000) begin
            ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start[k] = poke && n == 5;
            @(posedge clk);
            #1 n++;
        end
        start[k] = 1'b0;
        ready[k] = 1'b1;
        chk("done_seen", k, int'(done[k]), 1);
        if (exp_cyc >= 0) chk("cycles", k, n, exp_cyc);
        chk("xfers", k, xfers[k], exp_n);
        chk("eot_count", k, eot_cnt[k], 1);
        chk("last_x", k, lx[k], exp_x);
        chk("last_y", k, ly[k], exp_y);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_x", k, int'(px[k]), 0);
            chk("rst_y", k, int'(py[k]), 0);
            chk("rst_valid", k, int'(valid[k]), 0);
        end

        run_frame(0, 1'b0, 1'b0, 484, 484, 21, 21);
        run_frame(1, 1'b0, 1'b0, 36, 36, 20, 20);
        run_frame(2, 1'b0, 1'b0, 1, 1, 0, 0);
        run_frame(2, 1'b0, 1'b0, 1, 1, 0, 0);
        run_frame(0, 1'b1, 1'b0, -1, 484, 21, 21);
        run_frame(1, 1'b1, 1'b1, -1, 36, 20, 20);

        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        chk("done_start_ignored", 1, int'(busy[1]), 0);
        repeat (2) @(posedge clk);
        #1;

        xfers[0]   = 0;
        eot_cnt[0] = 0;
        start[0]   = 1'b1;
        ready[0]   = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_valid", 0, int'(valid[0]), 0);
        chk("mid_rst_busy", 0, int'(busy[0]), 0);
        chk("mid_rst_x", 0, int'(px[0]), 0);
        chk("mid_rst_y", 0, int'(py[0]), 0);
        chk("mid_rst_eot", 0, int'(eot[0]), 0);
        chk("mid_rst_xfers", 0, xfers[0], 100);
        chk("mid_rst_eot_count", 0, eot_cnt[0], 0);
`ifdef WINDOW_POS_GEN_FRAME_CNT_EN
        chk("fc_after_rst", 0, int'(fc[0]), 0);
`endif
        run_frame(0, 1'b0, 1'b0, 484, 484, 21, 21);
`ifdef WINDOW_POS_GEN_FRAME_CNT_EN
        chk("fc_one_frame", 0, int'(fc[0]), 1);
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_pos_gen.md
Name: window_pos_gen

Overview:
- Source side of the window-position stream. Walks a detection window across the image in raster order and emits one (x, y) position per handshake. Asserts eot on the last position of a frame.
- Sits upstream of the classifier and position-matching logic. Drives the window_pos_valid/ready/eot/x/y interface.
- A scan starts on a one-cycle start pulse and ends with a done pulse.

Parameters:
- IMG_WIDTH, 45, image width in pixels.
- IMG_HEIGHT, 45, image height in pixels.
- WIN_WIDTH, 24, detection window width; must be <= IMG_WIDTH.
- WIN_HEIGHT, 24, detection window height; must be <= IMG_HEIGHT.
- STEP, 1, scan stride in pixels for both x and y; must be >= 1.
- W_X (localparam), $clog2(IMG_WIDTH), x coordinate width.
- W_Y (localparam), $clog2(IMG_HEIGHT), y coordinate width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  scan request pulse; ignored unless FSM is IDLE
- busy  out  1  high in SCAN and DONE states
- done  out  1  one-cycle pulse after the eot position transfers
- window_pos_valid  out  1  position valid
- window_pos_ready  in  1  downstream accepts position
- window_pos_eot  out  1  current position is the last of the frame
- window_pos_x  out  W_X  window left column
- window_pos_y  out  W_Y  window top row

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - All state is registered. No combinational path from window_pos_ready to any output.
- Reset values: FSM=IDLE, window_pos_valid=0, window_pos_eot=0, x=0, y=0, busy=0, done=0.
- Scan limits: X_MAX = IMG_WIDTH-WIN_WIDTH and Y_MAX = IMG_HEIGHT-WIN_HEIGHT, both constants.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on start=1, load x=0, y=0, and go to SCAN. window_pos_valid rises the next cycle (1-cycle latency from start).
  - SCAN: window_pos_valid=1. A transfer occurs when valid&&ready.
  - On a transfer, if x+STEP <= X_MAX then x += STEP.
  - Otherwise x=0; then if y+STEP <= Y_MAX then y += STEP.
  - Otherwise the position just transferred was the last; go to DONE and drop valid.
  - DONE: done=1 for exactly one cycle, then IDLE.
- eot:
  - Registered, asserted together with the final position: x+STEP > X_MAX and y+STEP > Y_MAX.
  - Must not be asserted on any other position.
- Hold rule: while valid && !ready, x, y and eot are stable.
- Arithmetic:
  - Perform the next-position comparisons at W_X+1 / W_Y+1 bits so x+STEP cannot wrap.
  - Emitted coordinates never exceed X_MAX / Y_MAX.
- Boundaries:
  - X_MAX=0 and Y_MAX=0 (window equals image): one position (0,0) with eot=1.
  - STEP > X_MAX: one column, x=0 on every row.
- Simultaneous events:
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
  - rst during SCAN forces IDLE with valid=0 on the next edge. The partial frame is abandoned and no eot is emitted.
- Position count per frame: (X_MAX/STEP+1)*(Y_MAX/STEP+1), using integer division.

Optional Feature:
- Macro: WINDOW_POS_GEN_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt, 16 bits, reset to 0.
  - Increments by 1 (wrapping) in the cycle the eot position transfers.
  - Valid from the cycle done is high.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Shared package cascade_pkg holds:
  - the window_pos_gen_state_e enum (IDLE/SCAN/DONE);
  - default IMG_WIDTH/IMG_HEIGHT/WIN_WIDTH/WIN_HEIGHT constants, shared with the position-matching and classifier blocks.
- One natural sub-module: step_counter. It is an up-counter with STEP increment, MAX limit, clear and an "at_last" flag. It is instantiated twice, for x and y; y advances on the x counter's wrap.

Test Plan:
- Defaults (45/45/24/24, STEP=1), ready always 1, start pulse → 484 positions in 484 consecutive cycles. The first position (0,0) appears 1 cycle after start. eot appears only on (21,21). done follows 1 cycle after the last transfer.
- STEP=4, ready=1 → x and y each sweep {0,4,8,12,16,20}, giving 36 positions. Last position (20,20) with eot=1. No coordinate exceeds 21.
- Random ready backpressure (50%) → same sequence as the previous tests. x, y and eot are stable across every valid&&!ready cycle. Position count is unchanged.
- WIN equals IMG (45x45) → single position (0,0) with eot=1, then done. A second start afterwards repeats the identical result.
- Start pulses during SCAN and in the DONE cycle → ignored. Sequence and count are unaffected.
- rst asserted after 100 transfers → next cycle valid=0, busy=0, x=y=0, no eot. A fresh start restarts at (0,0). With WINDOW_POS_GEN_FRAME_CNT_EN, frame_cnt=0 after this reset and reads 1 after one full frame.
